// File: rtl/cmac_emitter_pkg.sv
// ---------------------------------------------------------------------------
// cmac_emitter_pkg
// Shared definitions for the CMAC TX length emitter: the kick FSM state
// encoding and the default parameter values used by the emitter and its
// length queue.
// Optional build macro (used by cmac_tx_len_emitter): CMAC_EMITTER_TIMEOUT_EN
// ---------------------------------------------------------------------------
package cmac_emitter_pkg;

    localparam int DEF_DATA_W      = 512;
    localparam int DEF_LEN_W       = 14;
    localparam int DEF_LEN_DEPTH   = 16;
    localparam int DEF_MAX_BYTES   = 9600;
    localparam int DEF_TIMEOUT_CYC = 65535;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_KICK      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } kick_state_t;

endpackage

// File: rtl/cmac_len_fifo.sv
// ---------------------------------------------------------------------------
// cmac_len_fifo
// First-word-fall-through queue of packet lengths. The head entry is visible
// on o_head whenever o_empty is low; i_pop retires it on the clock edge.
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties queue)
//   i_push, i_len     write one length (ignored when full)
//   i_pop             retire head entry (ignored when empty)
//   o_head, o_empty   head length and empty flag
//   o_count           number of queued lengths
// ---------------------------------------------------------------------------
module cmac_len_fifo
    import cmac_emitter_pkg::*;
#(
    parameter int LEN_W     = DEF_LEN_W,
    parameter int LEN_DEPTH = DEF_LEN_DEPTH,
    localparam int PTR_W    = $clog2(LEN_DEPTH),
    localparam int CNT_W    = $clog2(LEN_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_pop,
    output logic [LEN_W-1:0] o_head,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [LEN_W-1:0] r_mem [LEN_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == CNT_W'(LEN_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_len;
        end
    end

endmodule

// File: rtl/cmac_tx_len_emitter.sv
// ---------------------------------------------------------------------------
// cmac_tx_len_emitter
// Forwards a TX beat stream one cycle late, counts the bytes of every packet,
// queues the finished lengths and hands them one at a time to the CMAC with
// a kick / busy / done handshake.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   din_data/valid/sop/eop/mty      input beat stream, din_ready backpressure
//   dout_data, dout_valid           accepted beats delayed one cycle
//   dout_kick, dout_bytes           transmit request and its packet length
//   cmac_busy/done/tx_rdy           CMAC handshake
//   pkt_pending                     queued lengths
//   err_orphan, err_oversize        protocol-error and length-clamp pulses
//   err_timeout                     watchdog pulse (timeout build only)
// Build macro: CMAC_EMITTER_TIMEOUT_EN adds the kick/done watchdog and the
// err_timeout port; without it the FSM waits on the CMAC indefinitely.
//
// Kick FSM:
//   state     | meaning
//   ----------+-------------------------------------------------
//   IDLE      | no transfer outstanding, pops head when CMAC ready
//   KICK      | dout_kick high, waiting for cmac_busy
//   WAIT_DONE | CMAC transmitting, waiting for cmac_done
// ---------------------------------------------------------------------------
module cmac_tx_len_emitter
    import cmac_emitter_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int LEN_DEPTH   = DEF_LEN_DEPTH,
    parameter int MAX_BYTES   = DEF_MAX_BYTES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int BEAT_BYTES = DATA_W / 8,
    localparam int MTY_W      = $clog2(BEAT_BYTES),
    localparam int PEND_W     = $clog2(LEN_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din_data,
    input  logic              din_valid,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic [MTY_W-1:0]  din_mty,
    output logic              din_ready,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_valid,
    output logic              dout_kick,
    output logic [LEN_W-1:0]  dout_bytes,
    input  logic              cmac_busy,
    input  logic              cmac_done,
    input  logic              cmac_tx_rdy,
    output logic [PEND_W-1:0] pkt_pending,
    output logic              err_orphan,
`ifdef CMAC_EMITTER_TIMEOUT_EN
    output logic              err_timeout,
`endif
    output logic              err_oversize
);

    localparam logic [LEN_W:0] BEAT_L = (LEN_W + 1)'(BEAT_BYTES);
    localparam logic [LEN_W:0] MAX_L  = (LEN_W + 1)'(MAX_BYTES);

    logic              w_accept;
    logic [LEN_W:0]    w_beat_bytes;
    logic [LEN_W:0]    w_sum;
    logic [LEN_W:0]    w_sum_sat;
    logic              w_counted;
    logic [PEND_W:0]   w_occupancy;
    logic              w_pop;
    logic              w_empty;
    logic [LEN_W-1:0]  w_head;

    logic              r_in_pkt;
    logic [LEN_W:0]    r_acc;
    logic              r_push_vld;
    logic [LEN_W-1:0]  r_push_len;
    kick_state_t       r_state;

    // ---------------- input accounting ----------------
    assign w_accept     = din_valid && din_ready;
    assign w_beat_bytes = din_eop ? (BEAT_L - (LEN_W + 1)'(din_mty)) : BEAT_L;
    assign w_sum        = din_sop ? w_beat_bytes : (r_acc + w_beat_bytes);
    // Saturate just above MAX so long packets can never wrap the accumulator.
    assign w_sum_sat    = (w_sum > MAX_L) ? (MAX_L + 1'b1) : w_sum;
    assign w_counted    = din_sop || r_in_pkt;

    // The push sitting in r_push_vld is already committed, so it reserves a slot.
    assign w_occupancy  = (PEND_W + 1)'(pkt_pending) + (PEND_W + 1)'(r_push_vld);
    assign din_ready    = (w_occupancy < (PEND_W + 1)'(LEN_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_pkt     <= 1'b0;
            r_acc        <= '0;
            r_push_vld   <= 1'b0;
            r_push_len   <= '0;
            err_orphan   <= 1'b0;
            err_oversize <= 1'b0;
        end else begin
            r_push_vld   <= 1'b0;
            err_orphan   <= 1'b0;
            err_oversize <= 1'b0;
            if (w_accept) begin
                // sop inside a packet, or a continuation beat outside one
                err_orphan <= din_sop ? r_in_pkt : !r_in_pkt;
                if (w_counted) begin
                    if (din_eop) begin
                        r_in_pkt     <= 1'b0;
                        r_push_vld   <= 1'b1;
                        err_oversize <= (w_sum_sat > MAX_L);
                        r_push_len   <= (w_sum_sat > MAX_L) ? LEN_W'(MAX_BYTES)
                                                            : w_sum_sat[LEN_W-1:0];
                    end else begin
                        r_in_pkt <= 1'b1;
                        r_acc    <= w_sum_sat;
                    end
                end
            end
        end
    end

    // ---------------- data forwarding ----------------
    always_ff @(posedge clk) begin
        dout_data <= din_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= w_accept;
        end
    end

    // ---------------- length queue ----------------
    cmac_len_fifo #(
        .LEN_W     (LEN_W),
        .LEN_DEPTH (LEN_DEPTH)
    ) u_len_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_push_vld),
        .i_len   (r_push_len),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (pkt_pending)
    );

    // ---------------- kick FSM ----------------
    assign w_pop = (r_state == ST_IDLE) && !w_empty && cmac_tx_rdy;

`ifdef CMAC_EMITTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    // Down-counter loaded on entry to KICK; reaching zero ends the transfer.
    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            dout_kick   <= 1'b0;
            dout_bytes  <= '0;
            r_tmo_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state    <= ST_KICK;
                        dout_kick  <= 1'b1;
                        dout_bytes <= w_head;
                        r_tmo_cnt  <= TMO_W'(TIMEOUT_CYC - 1);
                    end
                end
                ST_KICK: begin
                    if (cmac_busy) begin
                        dout_kick <= 1'b0;
                        r_state   <= cmac_done ? ST_IDLE : ST_WAIT_DONE;
                        r_tmo_cnt <= r_tmo_cnt - 1'b1;
                    end else if (r_tmo_cnt == '0) begin
                        dout_kick   <= 1'b0;
                        r_state     <= ST_IDLE;
                        err_timeout <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (cmac_done) begin
                        r_state <= ST_IDLE;
                    end else if (r_tmo_cnt == '0) begin
                        r_state     <= ST_IDLE;
                        err_timeout <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    dout_kick <= 1'b0;
                end
            endcase
        end
    end
`else
    // The watchdog limit only matters in the timeout build; this empty block
    // keeps the parameter referenced so both builds share one parameter list.
    if (TIMEOUT_CYC < 1) begin : g_tmo_limit_unused
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            dout_kick  <= 1'b0;
            dout_bytes <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state    <= ST_KICK;
                        dout_kick  <= 1'b1;
                        dout_bytes <= w_head;
                    end
                end
                ST_KICK: begin
                    if (cmac_busy) begin
                        dout_kick <= 1'b0;
                        r_state   <= cmac_done ? ST_IDLE : ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (cmac_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    dout_kick <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_cmac_tx_len_emitter.sv
module tb_cmac_tx_len_emitter;

    localparam int DATA_W    = 512;
    localparam int LEN_W     = 14;
    localparam int LEN_DEPTH = 16;
    localparam int MAX_BYTES = 9600;
    localparam int BEAT      = DATA_W / 8;
    localparam int MTY_W     = $clog2(BEAT);
    localparam int PEND_W    = $clog2(LEN_DEPTH + 1);

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] din_data;
    logic              din_valid;
    logic              din_sop;
    logic              din_eop;
    logic [MTY_W-1:0]  din_mty;
    logic              din_ready;
    logic [DATA_W-1:0] dout_data;
    logic              dout_valid;
    logic              dout_kick;
    logic [LEN_W-1:0]  dout_bytes;
    logic              cmac_busy;
    logic              cmac_done;
    logic              cmac_tx_rdy;
    logic [PEND_W-1:0] pkt_pending;
    logic              err_orphan;
    logic              err_oversize;
`ifdef CMAC_EMITTER_TIMEOUT_EN
    logic              err_timeout;
`endif

    cmac_tx_len_emitter #(
        .DATA_W      (DATA_W),
        .LEN_W       (LEN_W),
        .LEN_DEPTH   (LEN_DEPTH),
        .MAX_BYTES   (MAX_BYTES),
        .TIMEOUT_CYC (65535)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din_data     (din_data),
        .din_valid    (din_valid),
        .din_sop      (din_sop),
        .din_eop      (din_eop),
        .din_mty      (din_mty),
        .din_ready    (din_ready),
        .dout_data    (dout_data),
        .dout_valid   (dout_valid),
        .dout_kick    (dout_kick),
        .dout_bytes   (dout_bytes),
        .cmac_busy    (cmac_busy),
        .cmac_done    (cmac_done),
        .cmac_tx_rdy  (cmac_tx_rdy),
        .pkt_pending  (pkt_pending),
        .err_orphan   (err_orphan),
`ifdef CMAC_EMITTER_TIMEOUT_EN
        .err_timeout  (err_timeout),
`endif
        .err_oversize (err_oversize)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model & scoreboard ----------------
    bit                m_in_pkt;
    int                m_acc;
    int                exp_len_q[$];
    logic [DATA_W-1:0] exp_data_q[$];
    int                exp_orphan, exp_oversize, obs_orphan, obs_oversize;
    bit                prev_kick;

    // Packet rules: a beat carries 64 bytes, the eop beat 64-mty; a packet is
    // opened by sop, closed by eop, and clamped to MAX_BYTES.
    task automatic model_beat();
        int bytes;
        bytes = din_eop ? (BEAT - int'(din_mty)) : BEAT;
        exp_data_q.push_back(din_data);
        if (din_sop) begin
            if (m_in_pkt) exp_orphan++;
            m_in_pkt = 1'b1;
            m_acc    = bytes;
        end else if (!m_in_pkt) begin
            exp_orphan++;
            return;
        end else begin
            m_acc += bytes;
        end
        if (din_eop) begin
            m_in_pkt = 1'b0;
            if (m_acc > MAX_BYTES) begin
                exp_oversize++;
                exp_len_q.push_back(MAX_BYTES);
            end else begin
                exp_len_q.push_back(m_acc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            m_in_pkt  = 1'b0;
            m_acc     = 0;
            exp_len_q.delete();
            exp_data_q.delete();
            prev_kick = 1'b0;
        end else begin
            if (dout_valid) begin
                checks++;
                if (exp_data_q.size() == 0) begin
                    errors++;
                    $display("FAIL dout_beat: got unexpected beat, expected none (t=%0t)", $time);
                end else if (dout_data !== exp_data_q[0]) begin
                    errors++;
                    $display("FAIL dout_data: got %h, expected %h", dout_data, exp_data_q[0]);
                    void'(exp_data_q.pop_front());
                end else begin
                    void'(exp_data_q.pop_front());
                end
            end
            if (err_orphan)   obs_orphan++;
            if (err_oversize) obs_oversize++;
            if (dout_kick && !prev_kick) begin
                if (exp_len_q.size() == 0) begin
                    chk("kick_unexpected", 1, 0);
                end else begin
                    chk("kick_bytes", dout_bytes, exp_len_q.pop_front());
                end
            end
            prev_kick = dout_kick;
            if (din_valid && din_ready) model_beat();
        end
    end

    // ---------------- CMAC responder ----------------
    int busy_delay = -1;
    initial begin
        cmac_busy = 1'b0;
        cmac_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && dout_kick) begin
                int d;
                bit both;
                d = (busy_delay >= 0) ? busy_delay : int'($urandom_range(0, 4));
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    chk("kick_held", dout_kick, 1);
                end
                @(posedge clk); #1;
                both      = ($urandom_range(0, 3) == 0);
                cmac_busy = 1'b1;
                cmac_done = both;
                @(posedge clk); #1;
                cmac_busy = 1'b0;
                cmac_done = 1'b0;
                @(negedge clk);
                chk("kick_drop_on_busy", dout_kick, 0);
                if (!both) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    #1 cmac_done = 1'b1;
                    @(posedge clk); #1;
                    cmac_done = 1'b0;
                end
            end
        end
    end

    bit rdy_rand = 1'b0;
    always begin
        @(posedge clk); #1;
        if (rdy_rand) cmac_tx_rdy = ($urandom_range(0, 3) != 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input bit sop, input bit eop, input int mty);
        logic [DATA_W-1:0] d;
        int n;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        din_data  = d;
        din_sop   = sop;
        din_eop   = eop;
        din_mty   = MTY_W'(mty);
        din_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (din_ready) break;
            n++;
            if (n > 2000) begin
                chk("send_stalled", 1, 0);
                break;
            end
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din_eop   = 1'b0;
    endtask

    task automatic wait_kick(input string name);
        int n;
        n = 0;
        while (!dout_kick && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!dout_kick) chk(name, 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_len_q.size() != 0 || pkt_pending != 0 || dout_kick) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 1, 0);
        cycles(15);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n, base;
        din_data = '0; din_valid = 0; din_sop = 0; din_eop = 0; din_mty = '0;
        cmac_tx_rdy = 1'b0;
        reset = 1'b1;
        cycles(3);
        @(negedge clk);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_kick", dout_kick, 0);
        chk("rst_dout_bytes", dout_bytes, 0);
        chk("rst_pkt_pending", pkt_pending, 0);
        chk("rst_err_orphan", err_orphan, 0);
        chk("rst_err_oversize", err_oversize, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", din_ready, 1);
        @(posedge clk); #1;

        // single beat, mty=4: kick 3 cycles after the beat, 60 bytes
        cmac_tx_rdy = 1'b1;
        send_beat(1, 1, 4);
        n = 0;
        while (!dout_kick && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("kick_latency", n, 3);
        chk("bytes_60", dout_bytes, 60);
        drain();

        // 3-beat packet, mty=10 on eop: 182 bytes, busy 5 cycles late
        busy_delay = 5;
        send_beat(1, 0, 0);
        send_beat(0, 0, 3);
        send_beat(0, 1, 10);
        wait_kick("kick_182_missing");
        chk("bytes_182", dout_bytes, 182);
        drain();
        busy_delay = -1;

        // fill the queue with the CMAC not ready
        cmac_tx_rdy = 1'b0;
        for (int i = 0; i < LEN_DEPTH; i++) send_beat(1, 1, int'($urandom_range(0, 63)));
        cycles(3);
        @(negedge clk);
        chk("full_pending", pkt_pending, LEN_DEPTH);
        chk("full_ready", din_ready, 0);
        @(posedge clk); #1;
        fork
            send_beat(1, 1, 7);
        join_none
        cycles(5);
        @(negedge clk);
        chk("stall_pending", pkt_pending, LEN_DEPTH);
        chk("stall_ready", din_ready, 0);
        @(posedge clk); #1;
        cmac_tx_rdy = 1'b1;
        wait fork;
        drain();

        // sop inside packet, then a lone continuation beat
        base = obs_orphan;
        send_beat(1, 0, 0);
        send_beat(0, 0, 0);
        send_beat(1, 1, 0);
        wait_kick("kick_64_missing");
        chk("bytes_restart_64", dout_bytes, 64);
        drain();
        send_beat(0, 0, 0);
        cycles(4);
        @(negedge clk);
        chk("lone_beat_no_push", pkt_pending, 0);
        @(posedge clk); #1;
        chk("orphan_pulses", obs_orphan - base, 2);

        // 160 beats = 10240 bytes, clamped
        base = obs_oversize;
        send_beat(1, 0, 0);
        for (int i = 0; i < 158; i++) send_beat(0, 0, 0);
        send_beat(0, 1, 0);
        wait_kick("kick_9600_missing");
        chk("bytes_clamped", dout_bytes, MAX_BYTES);
        drain();
        chk("oversize_pulses", obs_oversize - base, 1);

        // reset with queued lengths and a partial packet
        cmac_tx_rdy = 1'b0;
        send_beat(1, 1, 5);
        send_beat(1, 1, 9);
        send_beat(1, 0, 0);
        cycles(3);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_pending", pkt_pending, 0);
        chk("post_rst_ready", din_ready, 1);
        chk("post_rst_kick", dout_kick, 0);
        @(posedge clk); #1;
        cmac_tx_rdy = 1'b1;
        send_beat(0, 1, 20);
        send_beat(1, 0, 0);
        send_beat(0, 1, 33);
        drain();

        // randomized traffic with occasional framing errors
        rdy_rand = 1'b1;
        for (int p = 0; p < 60; p++) begin
            int nb;
            nb = (p % 17 == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(1, 5));
            for (int b = 0; b < nb; b++) begin
                bit s, e;
                s = (b == 0);
                e = (b == nb - 1);
                if ($urandom_range(0, 19) == 0) s = ~s;
                if ($urandom_range(0, 19) == 0) e = ~e;
                send_beat(s, e, int'($urandom_range(0, 63)));
                if ($urandom_range(0, 2) == 0) cycles(int'($urandom_range(1, 2)));
            end
        end
        rdy_rand = 1'b0;
        cycles(1);
        cmac_tx_rdy = 1'b1;
        drain();

        chk("total_orphan", obs_orphan, exp_orphan);
        chk("total_oversize", obs_oversize, exp_oversize);
        chk("lengths_left", exp_len_q.size(), 0);
        chk("beats_left", exp_data_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
